// File: rtl/div_if.sv
// Divide request/response bundle between ex_ctrl (master) and div_ctrl (slave).
// Valid/ready: master holds start_i until ready_o is seen, captures result_o that cycle, drops start_i next.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_req_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 shift-subtract divider controller for the EX stage (HI/LO = {remainder, quotient}).
// Define DIV_SIGNED_EN to honour signed_i; otherwise every divide is unsigned.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       div,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(WIDTH);

  state_t             state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH:0]   partial_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH-1:0]   quot_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH:0]     trial;

  // Remainder accumulates in the top W+1 bits; quotient bits shift in at the bottom.
  assign trial    = partial_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
  assign quot_raw = partial_q[WIDTH-1:0];
  assign rem_raw  = partial_q[2*WIDTH:WIDTH+1];

`ifdef DIV_SIGNED_EN
  logic neg1;
  logic neg2;
  logic neg_quot_q;
  logic neg_rem_q;

  assign neg1     = div.signed_i & div.opdata1_i[WIDTH-1];
  assign neg2     = div.signed_i & div.opdata2_i[WIDTH-1];
  assign mag1     = neg1 ? (~div.opdata1_i + 1'b1) : div.opdata1_i;
  assign mag2     = neg2 ? (~div.opdata2_i + 1'b1) : div.opdata2_i;
  assign quot_fix = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
  assign rem_fix  = neg_rem_q  ? (~rem_raw + 1'b1)  : rem_raw;
`else
  logic unused_signed;

  assign unused_signed = div.signed_i;
  assign mag1          = div.opdata1_i;
  assign mag2          = div.opdata2_i;
  assign quot_fix      = quot_raw;
  assign rem_fix       = rem_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      partial_q <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else if (div.annul_i && (state_q != S_IDLE)) begin
      // Flush abandons whatever is in flight, including a result awaiting pickup.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div.start_i && !div.annul_i) begin
            if (div.opdata2_i == '0) begin
              state_q <= S_DIVZERO;
            end else begin
              state_q   <= S_ON;
              cnt_q     <= '0;
              partial_q <= {{WIDTH{1'b0}}, mag1, 1'b0};
              divisor_q <= mag2;
`ifdef DIV_SIGNED_EN
              neg_quot_q <= neg1 ^ neg2;
              neg_rem_q  <= neg1;
`endif
            end
          end
        end
        S_DIVZERO: begin
          partial_q <= '0;
          result_q  <= '0;
          ready_q   <= 1'b1;
          state_q   <= S_END;
        end
        S_ON: begin
          if (cnt_q != CNT_LAST) begin
            if (trial[WIDTH]) begin
              partial_q <= {partial_q[2*WIDTH-1:0], 1'b0};
            end else begin
              partial_q <= {trial[WIDTH-1:0], partial_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem_fix, quot_fix};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_END: begin
          if (!div.start_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div.result_o    = result_q;
  assign div.ready_o     = ready_q;
  assign div.stall_req_o = div.start_i & ~ready_q & ~div.annul_i;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed + random bench for div_ctrl: latency, stall window, handshake, annul, reset and arithmetic.
module tb_div_ctrl;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  div_if #(.WIDTH(W)) dif ();

  div_ctrl #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .div         (dif),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // Reference model, written from the arithmetic definition.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    longint sa;
    longint sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) return '0;
    if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver: one full divide with handshake; hold = extra cycles start_i stays high in END.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int exp_lat, input int hold);
    logic [2*W-1:0] exp;
    int cyc;
    bit got;
    bit stall_ok;
    exp_q.push_back(model(a, b, sgn));
    @(posedge clk); #1;
    dif.start_i   = 1'b1;
    dif.signed_i  = sgn;
    dif.opdata1_i = a;
    dif.opdata2_i = b;
    cyc = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (dif.ready_o === 1'b1) got = 1'b1;
      else begin
        if (dif.stall_req_o !== 1'b1) stall_ok = 1'b0;
        cyc++;
        // Operands are scrambled once the divider has left IDLE; they must be ignored.
        if (cyc == 2) begin
          dif.opdata1_i = $urandom;
          dif.opdata2_i = $urandom;
          dif.signed_i  = ~sgn;
        end
      end
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("stall_before_ready", 64'(stall_ok), 64'd1);
    chk("stall_at_ready", 64'(dif.stall_req_o), 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("result", dif.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ready", 64'(dif.ready_o), 64'd1);
      chk("hold_result", dif.result_o, exp);
    end
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_ready", 64'(dif.ready_o), 64'd0);
    chk("drop_result", dif.result_o, 64'd0);
    chk("drop_state", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // Scoreboard-driven directed sequence
  initial begin
    bit saw_ready;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    rst           = 1'b1;
    dif.start_i   = 1'b0;
    dif.annul_i   = 1'b0;
    dif.signed_i  = 1'b0;
    dif.opdata1_i = '0;
    dif.opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_result", dif.result_o, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_stall", 64'(dif.stall_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 34, 0);
    run_div(32'd5, 32'd0, 1'b0, 2, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 34, 0);
    run_div(32'd20, 32'd3, 1'b0, 34, 3);

    // start and annul together in IDLE must not start
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.annul_i = 1'b1; dif.opdata1_i = 32'd9; dif.opdata2_i = 32'd3;
    @(negedge clk);
    chk("start_annul_stall", 64'(dif.stall_req_o), 64'd0);
    @(posedge clk); #1;
    dif.start_i = 1'b0; dif.annul_i = 1'b0;
    @(negedge clk);
    chk("start_annul_state", 64'(dbg_state), 64'(ST_IDLE));

    // annul at cycle 10 of an ON sequence
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1234; dif.opdata2_i = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    dif.annul_i = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("annul_result", dif.result_o, 64'd0);
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b0) saw_ready = 1'b1;
    end
    chk("annul_no_ready", 64'(saw_ready), 64'd0);
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, 34, 0);

    // reset at cycle 5 of an ON sequence
    @(posedge clk); #1;
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd777; dif.opdata2_i = 32'd7;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_ON));
    @(posedge clk); #1;
    rst = 1'b1; dif.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst_ready", 64'(dif.ready_o), 64'd0);
    chk("midrst_result", dif.result_o, 64'd0);
    run_div(32'd1000, 32'd33, 1'b0, 34, 0);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 0);
    run_div(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 34, 0);
    run_div(32'd3, 32'd10, 1'b0, 34, 0);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (rb == '0) rb = 32'd1;
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, 34, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle integer divider controller for the execute stage of the 5-stage MIPS32 pipeline. It accepts a divide request from `ex_ctrl` and sequences a radix-2 shift-subtract over WIDTH cycles. It holds the pipeline through a stall request until the quotient and remainder are ready, then hands back a {remainder, quotient} pair for HI/LO writeback. It also provides the annul path so a pipeline flush can abandon an in-flight division.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  divide request; level, held by `ex_ctrl` until ready_o seen.
- annul_i  in  1  cancel in-flight or pending division (flush).
- signed_i  in  1  1 = signed DIV, 0 = DIVU; sampled only in IDLE.
- opdata1_i  in  WIDTH  dividend; sampled only in IDLE.
- opdata2_i  in  WIDTH  divisor; sampled only in IDLE.
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; valid when ready_o=1.
- ready_o  out  1  registered; high for every cycle in END.
- stall_req_o  out  1  combinational: start_i & ~ready_o & ~annul_i; feeds pipeline stall control.

## Operation
- States: IDLE, DIVZERO, ON, END. 6-bit iteration counter cnt. Internal 2*WIDTH+1-bit partial register.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i=0 -> DIVZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 -> ON, cnt=0. Latch operand magnitudes and signs. Partial = {0, |dividend|, 1'b0}.
  - Otherwise stay in IDLE.
- DIVZERO: partial cleared -> END. No exception; result is all-zero.
- ON, cnt<WIDTH, one iteration per cycle:
  - trial = partial[2W:W] - {1'b0, divisor}.
  - trial negative: shift left, quotient bit 0.
  - Else: replace upper part with trial, shift left, quotient bit 1.
  - cnt++.
- ON, cnt==WIDTH: apply sign correction, latch result -> END.
- END: result_o and ready_o=1.
  - start_i=0 -> IDLE; result_o and ready_o cleared.
  - start_i=1 -> stay in END and hold the result.
- annul_i=1 in DIVZERO, ON or END -> IDLE next cycle; result_o=0, ready_o=0. In IDLE, annul_i blocks the start.
- Arithmetic:
  - Unsigned: quotient = floor(a/b), remainder = a - q*b.
  - Signed:
    - Quotient truncates toward zero and is negated when the operand signs differ.
    - Remainder takes the dividend's sign.
    - 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0.
- Operand changes after IDLE are ignored.

## Timing
- Reset: state=IDLE, cnt=0, partial=0, result_o=0, ready_o=0. stall_req_o follows its equation.
- Reset mid-operation wins over all other inputs and aborts the division.
- Latency, counted from the cycle start_i is sampled in IDLE (cycle 0):
  - Normal: ON occupies cycles 1..WIDTH+1; ready_o=1 at cycle WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: ready_o=1 at cycle 2.
- stall_req_o is high from cycle 0 until the cycle ready_o rises, then low.
- Handshake:
  - The consumer captures result_o in the first cycle ready_o=1.
  - It must drop start_i in the following cycle.
  - Back-to-back divides need one IDLE cycle between them.
- Simultaneous start_i=1 and annul_i=1 in IDLE: no start.

## Configuration
- DIV_SIGNED_EN defined: signed_i is honoured. Magnitude conversion at entry, then sign correction at cnt==WIDTH.
- DIV_SIGNED_EN undefined: signed_i is ignored and every operation is unsigned. The negation logic is not built.

## Test plan
- Unsigned 100/7, start held: stall_req_o high cycles 0–33; ready_o=1 at cycle 34; result_o = {0x00000002, 0x0000000E}. Drop start_i -> ready_o=0 and result_o=0 next cycle.
- 5/0: DIVZERO path; ready_o=1 at cycle 2, result_o=0; state returns to IDLE after start_i drops.
- Signed 0xFFFFFFF9 / 2:
  - With DIV_SIGNED_EN: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Without it: quotient 0x7FFFFFFC, remainder 0x00000001.
- Annul and restart: annul_i pulsed at cycle 10 -> IDLE at cycle 11, ready_o never rises. New start with 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0xF after 34 cycles.
- rst=1 at cycle 5 of an ON sequence: next cycle state=IDLE, ready_o=0, result_o=0. A subsequent division completes correctly.
- Signed 0x80000000 / 0xFFFFFFFF (macro on): quotient 0x80000000, remainder 0; ready_o=1 at cycle 34.
